// File: rtl/switch_conditioner_pkg.sv
// Shared definitions for the switch conditioner.
// - sw_state_t : per-channel debounce FSM state (2-bit encoding; bit 0 set
//                exactly in the two qualifying states)
// - DEFAULT_DEBOUNCE : stable-cycle count used for simulation builds
package switch_conditioner_pkg;

  typedef enum logic [1:0] {
    STABLE_OFF = 2'd0,
    CHK_ON     = 2'd1,
    STABLE_ON  = 2'd2,
    CHK_OFF    = 2'd3
  } sw_state_t;

  localparam int DEFAULT_DEBOUNCE = 16;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, stable-time debounce FSM and
// registered level / press / release / busy outputs.
// Ports:
//   clk   in  system clock
//   reset in  async active-low reset
//   raw   in  raw switch pin (asynchronous)
//   level out debounced state, 1 = pressed
//   press out one-cycle pulse on accepted press
//   rel   out one-cycle pulse on accepted release
//   busy  out high while a change is being qualified
module debounce_channel
  import switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic busy
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Pin level that means "not pressed"; synchroniser resets to it so no
  // phantom press is seen coming out of reset.
  localparam logic IDLE_PIN = ACTIVE_LOW;

  logic [1:0]       sync;
  logic             pressed;
  sw_state_t        state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= {2{IDLE_PIN}};
    else        sync <= {sync[0], raw};
  end

  // Internal sense is always active-high.
  assign pressed = sync[1] ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= STABLE_OFF;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        STABLE_OFF: if (pressed) begin
          state <= CHK_ON;
          cnt   <= '0;
        end
        CHK_ON: begin
          if (!pressed) begin
            state <= STABLE_OFF;  // glitch rejected
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= STABLE_ON;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_ON: if (!pressed) begin
          state <= CHK_OFF;
          cnt   <= '0;
        end
        CHK_OFF: begin
          if (pressed) begin
            state <= STABLE_ON;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= STABLE_OFF;
            cnt   <= '0;
            level <= 1'b0;
            rel   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE_OFF;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Straight off the state flops, so glitch-free.
  assign busy = (state == CHK_ON) || (state == CHK_OFF);

endmodule

// File: rtl/switch_conditioner.sv
// Conditions NUM_SW raw bouncing push switches into clean, clk-synchronous
// levels and press/release pulses. Channels are fully independent.
// Ports:
//   clk        in  system clock
//   reset      in  async active-low reset
//   sw_raw     in  [NUM_SW] raw switch pins
//   sw_level   out [NUM_SW] debounced state, 1 = pressed
//   sw_press   out [NUM_SW] one-cycle press pulses
//   sw_release out [NUM_SW] one-cycle release pulses
//   sw_busy    out [NUM_SW] channel qualifying a change
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int NUM_SW          = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_level,
  output logic [NUM_SW-1:0] sw_press,
  output logic [NUM_SW-1:0] sw_release,
  output logic [NUM_SW-1:0] sw_busy
);

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (sw_raw[i]),
      .level(sw_level[i]),
      .press(sw_press[i]),
      .rel  (sw_release[i]),
      .busy (sw_busy[i])
    );
  end

endmodule
